// File: rtl/tdm_mac_pkg.sv
// tdm_mac shared types: FSM states, slot-count helpers, saturation.
// Optional clamp is built when TDM_MAC_SAT_EN is defined.
package tdm_mac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Widest operand the clamp helper supports.
  localparam int MAXW = 64;

  typedef logic [2*MAXW:0] wide_t;

  function automatic int num_slots(
    input int units,
    input int lanes
  );
    return units / lanes;
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Clamp a sign-extended sum to a w-bit range.
  // Returns {clamped, value[MAXW-1:0]}.
  function automatic logic [MAXW:0] saturate(
    input wide_t v,
    input int    w,
    input logic  sgn
  );
    wide_t one;
    wide_t hi;
    wide_t lo;
    logic [MAXW:0] r;
    one = 1;
    r   = {1'b0, v[MAXW-1:0]};
    if (sgn) begin
      hi = (one << (w - 1)) - one;
      lo = ~hi;
      if ($signed(v) > $signed(hi))
        r = {1'b1, hi[MAXW-1:0]};
      else if ($signed(v) < $signed(lo))
        r = {1'b1, lo[MAXW-1:0]};
    end else begin
      hi = (one << w) - one;
      if (v > hi)
        r = {1'b1, hi[MAXW-1:0]};
    end
    return r;
  endfunction

endpackage

// File: rtl/tdm_mac_if.sv
// Issue/result bundle between the tdm_mac scheduler and one lane.
// master: scheduler side, slave: lane side.
interface tdm_mac_if #(
  parameter int W  = 32,
  parameter int TW = 2
);

  logic          iss_v;
  logic [W-1:0]  iss_a;
  logic [W-1:0]  iss_b;
  logic [W-1:0]  iss_c;
  logic [TW-1:0] iss_tag;

  logic          res_v;
  logic [W-1:0]  res_y;
  logic          res_sat;
  logic [TW-1:0] res_tag;

  modport master (
    output iss_v, iss_a, iss_b, iss_c, iss_tag,
    input  res_v, res_y, res_sat, res_tag
  );

  modport slave (
    input  iss_v, iss_a, iss_b, iss_c, iss_tag,
    output res_v, res_y, res_sat, res_tag
  );

endinterface

// File: rtl/tdm_mac_lane.sv
// One physical MAC lane: y = ((a*b) >>> FIXED_POINT) + c.
// Stage 1 registers the full product, stage 2 the shifted sum.
// Ports: i_clk, i_rst_n (async, low), lif (slave bundle).
// TDM_MAC_SAT_EN adds the clamp; otherwise the result wraps.
module tdm_mac_lane
  import tdm_mac_pkg::*;
#(
  parameter int C_WIDTH     = 32,
  parameter int FIXED_POINT = 8,
  parameter int SIGNED      = 1,
  parameter int TW          = 2
) (
  input  logic      i_clk,
  input  logic      i_rst_n,
  tdm_mac_if.slave  lif
);

  localparam int  W   = C_WIDTH;
  localparam int  PW  = 2 * W;
  localparam bit  SGN = (SIGNED != 0);

  logic [PW-1:0] w_ae;
  logic [PW-1:0] w_be;
  logic [PW-1:0] w_prod;

  logic          r_v1;
  logic [TW-1:0] r_t1;
  logic [PW-1:0] r_prod;
  logic [W-1:0]  r_c;

  logic [PW:0]   w_pe;
  logic [PW:0]   w_sh;
  logic [PW:0]   w_ce;
  logic [PW:0]   w_sum;
  logic [W-1:0]  w_y;
  logic          w_sat;
  logic          w_unused;

  logic          r_v2;
  logic [TW-1:0] r_t2;
  logic [W-1:0]  r_y;
  logic          r_sat;

  // Extend to 2W so a plain multiply yields the exact product.
  assign w_ae   = {{W{SGN & lif.iss_a[W-1]}}, lif.iss_a};
  assign w_be   = {{W{SGN & lif.iss_b[W-1]}}, lif.iss_b};
  assign w_prod = w_ae * w_be;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_v1   <= 1'b0;
      r_t1   <= '0;
      r_prod <= '0;
      r_c    <= '0;
    end else begin
      r_v1 <= lif.iss_v;
      if (lif.iss_v) begin
        r_t1   <= lif.iss_tag;
        r_prod <= w_prod;
        r_c    <= lif.iss_c;
      end
    end
  end

  // Top bit carries the sign (0 when unsigned), so an
  // arithmetic shift doubles as a logical one.
  assign w_pe  = {SGN & r_prod[PW-1], r_prod};
  assign w_sh  = $signed(w_pe) >>> FIXED_POINT;
  assign w_ce  = {{(W+1){SGN & r_c[W-1]}}, r_c};
  assign w_sum = w_sh + w_ce;

`ifdef TDM_MAC_SAT_EN
  logic [MAXW:0] w_clip;
  assign w_clip   = saturate(wide_t'($signed(w_sum)), W, SGN);
  assign w_y      = w_clip[W-1:0];
  assign w_sat    = w_clip[MAXW];
  assign w_unused = ^{w_clip, w_sum};
`else
  assign w_y      = w_sum[W-1:0];
  assign w_sat    = 1'b0;
  assign w_unused = ^w_sum;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_v2  <= 1'b0;
      r_t2  <= '0;
      r_y   <= '0;
      r_sat <= 1'b0;
    end else begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_t2  <= r_t1;
        r_y   <= w_y;
        r_sat <= w_sat;
      end
    end
  end

  assign lif.res_v   = r_v2;
  assign lif.res_tag = r_t2;
  assign lif.res_y   = r_y;
  assign lif.res_sat = r_sat;

endmodule

// File: rtl/tdm_mac.sv
// Time-multiplexed fixed-point MAC: NUM_UNITS channels shared
// over NUM_LANES lanes, one frame per start request.
// Ports: ctl_clk, ctl_rst (async, low), start, multiplicands,
// multipliers, addends (packed per channel), products,
// sat_flags, busy, done (1-cycle strobe).
// TDM_MAC_SAT_EN enables clamping and sat_flags.
module tdm_mac
  import tdm_mac_pkg::*;
#(
  parameter int C_WIDTH     = 32,
  parameter int FIXED_POINT = 8,
  parameter int NUM_UNITS   = 8,
  parameter int NUM_LANES   = 2,
  parameter int SIGNED      = 1
) (
  input  logic                         ctl_clk,
  input  logic                         ctl_rst,
  input  logic                         start,
  input  logic [C_WIDTH*NUM_UNITS-1:0] multiplicands,
  input  logic [C_WIDTH*NUM_UNITS-1:0] multipliers,
  input  logic [C_WIDTH*NUM_UNITS-1:0] addends,
  output logic [C_WIDTH*NUM_UNITS-1:0] products,
  output logic [NUM_UNITS-1:0]         sat_flags,
  output logic                         busy,
  output logic                         done
);

  localparam int S  = num_slots(NUM_UNITS, NUM_LANES);
  localparam int TW = idx_w(S);
  localparam int CW = idx_w(NUM_UNITS);
  localparam int BW = C_WIDTH * NUM_UNITS;
  localparam int IW = idx_w(BW);

  state_t        r_state;
  state_t        w_next;
  logic [TW-1:0] r_slot;
  logic          r_drn;
  logic          w_last;

  logic          w_snap;
  logic          w_issue;
  logic          w_load;
  logic          w_busy;

  logic [BW-1:0] r_a;
  logic [BW-1:0] r_b;
  logic [BW-1:0] r_c;
  logic [BW-1:0] r_bank;
  logic [BW-1:0] r_prods;
  logic          r_done;

  logic               w_rv [NUM_LANES];
  logic [C_WIDTH-1:0] w_ry [NUM_LANES];
  logic               w_rs [NUM_LANES];
  logic [CW-1:0]      w_wc [NUM_LANES];
  logic [IW-1:0]      w_wb [NUM_LANES];

  assign w_last = (r_slot == TW'(S - 1));

  always_ff @(posedge ctl_clk or negedge ctl_rst) begin
    if (!ctl_rst)
      r_state <= ST_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (start)  w_next = ST_RUN;
      ST_RUN:   if (w_last) w_next = ST_DRAIN;
      ST_DRAIN: if (r_drn)  w_next = ST_DONE;
      ST_DONE:              w_next = ST_IDLE;
      default:              w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_snap  = 1'b0;
    w_issue = 1'b0;
    w_load  = 1'b0;
    w_busy  = 1'b1;
    unique case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        w_snap = start;
      end
      ST_RUN:   w_issue = 1'b1;
      ST_DRAIN: ;
      ST_DONE:  w_load = 1'b1;
      default:  w_busy = 1'b0;
    endcase
  end

  // r_drn counts the two drain cycles that flush both
  // lane stages into the result bank.
  always_ff @(posedge ctl_clk or negedge ctl_rst) begin
    if (!ctl_rst) begin
      r_slot <= '0;
      r_drn  <= 1'b0;
    end else begin
      r_slot <= (w_issue && !w_last) ? r_slot + 1'b1 : '0;
      r_drn  <= (r_state == ST_DRAIN) && !r_drn;
    end
  end

  always_ff @(posedge ctl_clk or negedge ctl_rst) begin
    if (!ctl_rst) begin
      r_a <= '0;
      r_b <= '0;
      r_c <= '0;
    end else if (w_snap) begin
      r_a <= multiplicands;
      r_b <= multipliers;
      r_c <= addends;
    end
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    tdm_mac_if #(.W(C_WIDTH), .TW(TW)) u_if ();
    logic [IW-1:0] w_ib;

    assign w_ib = IW'((32'(r_slot) * NUM_LANES + k) * C_WIDTH);

    assign u_if.iss_v   = w_issue;
    assign u_if.iss_tag = r_slot;
    assign u_if.iss_a   = r_a[w_ib +: C_WIDTH];
    assign u_if.iss_b   = r_b[w_ib +: C_WIDTH];
    assign u_if.iss_c   = r_c[w_ib +: C_WIDTH];

    assign w_rv[k] = u_if.res_v;
    assign w_ry[k] = u_if.res_y;
    assign w_rs[k] = u_if.res_sat;
    assign w_wc[k] = CW'(32'(u_if.res_tag) * NUM_LANES + k);
    assign w_wb[k] = IW'(32'(w_wc[k]) * C_WIDTH);

    tdm_mac_lane #(
      .C_WIDTH     (C_WIDTH),
      .FIXED_POINT (FIXED_POINT),
      .SIGNED      (SIGNED),
      .TW          (TW)
    ) u_lane (
      .i_clk   (ctl_clk),
      .i_rst_n (ctl_rst),
      .lif     (u_if)
    );
  end

  // Lane results land in a private bank; the visible
  // outputs change only on the DONE edge.
  always_ff @(posedge ctl_clk or negedge ctl_rst) begin
    if (!ctl_rst) begin
      r_bank <= '0;
    end else begin
      for (int k = 0; k < NUM_LANES; k++)
        if (w_rv[k])
          r_bank[w_wb[k] +: C_WIDTH] <= w_ry[k];
    end
  end

  always_ff @(posedge ctl_clk or negedge ctl_rst) begin
    if (!ctl_rst) begin
      r_prods <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_load;
      if (w_load)
        r_prods <= r_bank;
    end
  end

`ifdef TDM_MAC_SAT_EN
  logic [NUM_UNITS-1:0] r_sbank;
  logic [NUM_UNITS-1:0] r_sflags;

  always_ff @(posedge ctl_clk or negedge ctl_rst) begin
    if (!ctl_rst) begin
      r_sbank  <= '0;
      r_sflags <= '0;
    end else begin
      for (int k = 0; k < NUM_LANES; k++)
        if (w_rv[k])
          r_sbank[w_wc[k]] <= w_rs[k];
      if (w_load)
        r_sflags <= r_sbank;
    end
  end

  assign sat_flags = r_sflags;
`else
  logic [NUM_LANES-1:0] w_unused_sat;
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_nosat
    assign w_unused_sat[k] = w_rs[k];
  end
  assign sat_flags = '0;
`endif

  assign products = r_prods;
  assign busy     = w_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_tdm_mac.sv
// Directed bench for tdm_mac with a frame scoreboard.
// Expected frames come from a longint reference model.
module tb_tdm_mac;

  localparam int W  = 32;
  localparam int N  = 8;
  localparam int BW = W * N;

`ifdef TDM_MAC_SAT_EN
  localparam logic [W-1:0] BIG_Y = 32'h7FFFFFFF;
  localparam logic [N-1:0] BIG_S = 8'hFF;
`else
  localparam logic [W-1:0] BIG_Y = 32'hFF000000;
  localparam logic [N-1:0] BIG_S = 8'h00;
`endif

  logic          ctl_clk = 1'b0;
  logic          ctl_rst = 1'b0;
  logic          start   = 1'b0;
  logic [BW-1:0] mc = '0;
  logic [BW-1:0] mp = '0;
  logic [BW-1:0] ad = '0;
  logic [BW-1:0] products;
  logic [N-1:0]  sat_flags;
  logic          busy;
  logic          done;

  int total    = 0;
  int bad      = 0;
  int done_cnt = 0;

  logic [BW-1:0] q_p [$];
  logic [N-1:0]  q_s [$];

  tdm_mac #(
    .C_WIDTH     (W),
    .FIXED_POINT (8),
    .NUM_UNITS   (N),
    .NUM_LANES   (2),
    .SIGNED      (1)
  ) dut (
    .ctl_clk       (ctl_clk),
    .ctl_rst       (ctl_rst),
    .start         (start),
    .multiplicands (mc),
    .multipliers   (mp),
    .addends       (ad),
    .products      (products),
    .sat_flags     (sat_flags),
    .busy          (busy),
    .done          (done)
  );

  always #5 ctl_clk = ~ctl_clk;

  always @(negedge ctl_clk)
    if (done === 1'b1) done_cnt <= done_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [W:0] model1(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic [W-1:0] c
  );
    longint p;
    longint s;
    p = longint'($signed(a)) * longint'($signed(b));
    p = p >>> 8;
    s = p + longint'($signed(c));
`ifdef TDM_MAC_SAT_EN
    if (s > 64'sd2147483647)
      return {1'b1, 32'h7FFFFFFF};
    if (s < -64'sd2147483648)
      return {1'b1, 32'h80000000};
`endif
    return {1'b0, s[31:0]};
  endfunction

  task automatic tick();
    @(posedge ctl_clk);
    #1;
  endtask

  task automatic chk(
    input string         tag,
    input logic [BW-1:0] obs,
    input logic [BW-1:0] exp
  );
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp();
    logic [BW-1:0] p;
    logic [N-1:0]  s;
    logic [W:0]    r;
    for (int i = 0; i < N; i++) begin
      r = model1(mc[i*W +: W], mp[i*W +: W], ad[i*W +: W]);
      p[i*W +: W] = r[W-1:0];
      s[i] = r[W];
    end
    q_p.push_back(p);
    q_s.push_back(s);
  endtask

  task automatic chk_sb(input string tag);
    int sz;
    sz = q_p.size();
    total++;
    assert (sz != 0) else begin
      bad++;
      $error("FAIL %s_sb obs=empty exp=entry", tag);
    end
    if (sz != 0) begin
      chk({tag, "_prod"}, products, q_p.pop_front());
      chk({tag, "_sat"}, BW'(sat_flags), BW'(q_s.pop_front()));
    end
  endtask

  task automatic set_all(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic [W-1:0] c
  );
    mc = {N{a}};
    mp = {N{b}};
    ad = {N{c}};
  endtask

  task automatic rand_ops();
    logic [W-1:0] v;
    for (int i = 0; i < N; i++) begin
      v = $urandom();
      if (i % 2 == 1) v = {{16{v[15]}}, v[15:0]};
      mc[i*W +: W] = v;
      v = $urandom();
      if (i % 3 != 0) v = {{16{v[15]}}, v[15:0]};
      mp[i*W +: W] = v;
      ad[i*W +: W] = $urandom();
    end
  endtask

  task automatic start_frame();
    start = 1'b1;
    push_exp();
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(
    input  string tag,
    input  int    exp_lat,
    output int    lat
  );
    bit hit;
    bit bz;
    hit = 1'b0;
    bz  = 1'b1;
    lat = 0;
    for (int i = 1; i <= 20 && !hit; i++) begin
      if (busy !== 1'b1) bz = 1'b0;
      tick();
      lat = i;
      if (done === 1'b1) hit = 1'b1;
    end
    if (!hit) lat = -1;
    chk({tag, "_lat"}, BW'(lat), BW'(exp_lat));
    chk({tag, "_busy"}, BW'(bz), BW'(1));
    chk({tag, "_busy_end"}, BW'(busy), '0);
    chk_sb(tag);
  endtask

  initial begin
    int lat;
    int d0;
    int acc;

    ctl_rst = 1'b0;
    repeat (2) @(posedge ctl_clk);
    #1;
    chk("rst_prod", products, '0);
    chk("rst_sat", BW'(sat_flags), '0);
    chk("rst_busy", BW'(busy), '0);
    chk("rst_done", BW'(done), '0);
    ctl_rst = 1'b1;
    tick();

    set_all(32'h300, 32'h200, 32'h100);
    d0 = done_cnt;
    start_frame();
    wait_done("basic", 7, lat);
    chk("basic_const", products, {N{32'h700}});
    tick();
    chk("basic_done_low", BW'(done), '0);
    chk("basic_one_pulse", BW'(done_cnt - d0), BW'(1));

    set_all(32'hFFFFFE00, 32'h180, 32'h0);
    start_frame();
    wait_done("neg", 7, lat);
    chk("neg_const", BW'(products[W-1:0]), BW'(32'hFFFFFD00));
    tick();
    chk("hold_prod", BW'(products[W-1:0]), BW'(32'hFFFFFD00));

    set_all(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h0);
    start_frame();
    wait_done("big", 7, lat);
    chk("big_const", BW'(products[W-1:0]), BW'(BIG_Y));
    chk("big_flags", BW'(sat_flags), BW'(BIG_S));
    tick();

    rand_ops();
    d0 = done_cnt;
    start_frame();
    for (int i = 1; i <= 6; i++) begin
      start = (i % 2 == 1);
      rand_ops();
      tick();
    end
    start = 1'b0;
    wait_done("ignore", 1, lat);
    tick();
    tick();
    chk("ignore_one_done", BW'(done_cnt - d0), BW'(1));
    chk("ignore_idle", BW'(busy), '0);

    rand_ops();
    start_frame();
    tick();
    tick();
    #2;
    ctl_rst = 1'b0;
    #1;
    chk("abort_prod", products, '0);
    chk("abort_sat", BW'(sat_flags), '0);
    chk("abort_busy", BW'(busy), '0);
    chk("abort_done", BW'(done), '0);
    void'(q_p.pop_back());
    void'(q_s.pop_back());
    d0 = done_cnt;
    @(posedge ctl_clk);
    #1;
    ctl_rst = 1'b1;
    repeat (10) tick();
    chk("abort_no_done", BW'(done_cnt - d0), '0);
    rand_ops();
    start_frame();
    wait_done("after_rst", 7, lat);
    tick();

    d0 = done_cnt;
    rand_ops();
    start = 1'b1;
    push_exp();
    tick();
    acc = 0;
    rand_ops();
    push_exp();
    wait_done("cont1", 7, lat);
    acc = acc + lat;
    chk("cont1_at", BW'(acc), BW'(7));
    tick();
    acc = acc + 1;
    rand_ops();
    push_exp();
    wait_done("cont2", 7, lat);
    acc = acc + lat;
    chk("cont2_at", BW'(acc), BW'(15));
    tick();
    acc = acc + 1;
    start = 1'b0;
    wait_done("cont3", 7, lat);
    acc = acc + lat;
    chk("cont3_at", BW'(acc), BW'(23));
    tick();
    tick();
    chk("cont_pulses", BW'(done_cnt - d0), BW'(3));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
